// File: rtl/s_des.sv
// rtl/s_des.sv - Simplified-DES encrypt/decrypt engine with registered output
module s_des (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       encrypt,
  input  logic [9:0] key,
  input  logic [7:0] plaintext,
  output logic [7:0] ciphertext,
  output logic       done
);

  // S0 lookup: row = {bit1, bit4}, col = {bit2, bit3}
  function automatic logic [1:0] sbox0(input logic [3:0] n);
    logic [1:0] v;
    case ({n[3], n[0], n[2], n[1]})
      4'd0:  v = 2'd1;  4'd1:  v = 2'd0;  4'd2:  v = 2'd3;  4'd3:  v = 2'd2;
      4'd4:  v = 2'd3;  4'd5:  v = 2'd2;  4'd6:  v = 2'd1;  4'd7:  v = 2'd0;
      4'd8:  v = 2'd0;  4'd9:  v = 2'd2;  4'd10: v = 2'd1;  4'd11: v = 2'd3;
      4'd12: v = 2'd3;  4'd13: v = 2'd1;  4'd14: v = 2'd3;  default: v = 2'd2;
    endcase
    return v;
  endfunction

  // S1 lookup: same row/column addressing as S0
  function automatic logic [1:0] sbox1(input logic [3:0] n);
    logic [1:0] v;
    case ({n[3], n[0], n[2], n[1]})
      4'd0:  v = 2'd0;  4'd1:  v = 2'd1;  4'd2:  v = 2'd2;  4'd3:  v = 2'd3;
      4'd4:  v = 2'd2;  4'd5:  v = 2'd0;  4'd6:  v = 2'd1;  4'd7:  v = 2'd3;
      4'd8:  v = 2'd3;  4'd9:  v = 2'd0;  4'd10: v = 2'd1;  4'd11: v = 2'd0;
      4'd12: v = 2'd2;  4'd13: v = 2'd1;  4'd14: v = 2'd0;  default: v = 2'd3;
    endcase
    return v;
  endfunction

  // Round function: EP expansion, key mix, S-boxes, P4
  function automatic logic [3:0] f_round(input logic [3:0] r, input logic [7:0] k);
    logic [7:0] x;
    logic [3:0] s;
    x = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ k;
    s = {sbox0(x[7:4]), sbox1(x[3:0])};
    return {s[2], s[0], s[1], s[3]};
  endfunction

  // P8 selects 8 of the 10 shifted key bits
  function automatic logic [7:0] p8(input logic [9:0] v);
    return {v[4], v[7], v[3], v[6], v[2], v[5], v[0], v[1]};
  endfunction

  logic [9:0] p10;
  logic [4:0] hl, hr;
  logic [7:0] k1, k2, ka, kb;
  logic [7:0] ip;
  logic [3:0] l0, r0, l1, l2;
  logic [7:0] result;

  // Key schedule: P10, per-half rotations by 1 and 3, then P8
  assign p10 = {key[7], key[5], key[8], key[3], key[6], key[0], key[9], key[1], key[2], key[4]};
  assign hl  = p10[9:5];
  assign hr  = p10[4:0];
  assign k1  = p8({hl[3:0], hl[4], hr[3:0], hr[4]});
  assign k2  = p8({hl[1:0], hl[4:2], hr[1:0], hr[4:2]});

  // Decryption is the same network with the subkey order reversed
  assign ka = encrypt ? k1 : k2;
  assign kb = encrypt ? k2 : k1;

  // Two Feistel rounds with the half swap folded into the wiring
  assign ip     = {plaintext[6], plaintext[2], plaintext[5], plaintext[7],
                   plaintext[4], plaintext[0], plaintext[3], plaintext[1]};
  assign l0     = ip[7:4];
  assign r0     = ip[3:0];
  assign l1     = l0 ^ f_round(r0, ka);
  assign l2     = r0 ^ f_round(l1, kb);
  assign result = {l2[0], l2[3], l2[1], l1[3], l1[1], l2[2], l1[0], l1[2]};

  // Output register: capture on start, hold otherwise, done pulses per request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ciphertext <= 8'h00;
      done       <= 1'b0;
    end else begin
      done <= start;
      if (start) begin
        ciphertext <= result;
      end
    end
  end

endmodule

// File: tb/tb_s_des.sv
// tb/tb_s_des.sv - scoreboard testbench for s_des with a table-driven S-DES model
`timescale 1ns/1ps
module tb_s_des;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       encrypt;
  logic [9:0] key;
  logic [7:0] plaintext;
  logic [7:0] ciphertext;
  logic       done;

  int checks = 0;
  int passes = 0;
  logic [7:0] sb[$];
  logic [7:0] last_exp;

  s_des dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .encrypt   (encrypt),
    .key       (key),
    .plaintext (plaintext),
    .ciphertext(ciphertext),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 1-based permutation tables and S-box arrays
  int P10_T[10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  int P8_T[10]  = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
  int IP_T[10]  = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
  int IPI_T[10] = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
  int EP_T[10]  = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
  int P4_T[10]  = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
  int S0[4][4]  = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
  int S1[4][4]  = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

  function automatic int unsigned perm(input int unsigned v, input int in_w, input int n, input int t[10]);
    int unsigned r;
    r = 0;
    for (int i = 0; i < n; i++) r = (r << 1) | ((v >> (in_w - t[i])) & 1);
    return r;
  endfunction

  function automatic int unsigned rotl5(input int unsigned h, input int s);
    return ((h << s) | (h >> (5 - s))) & 32'h1f;
  endfunction

  function automatic int unsigned f_model(input int unsigned r, input int unsigned k);
    int unsigned e, a, b, s0, s1;
    e  = perm(r, 4, 8, EP_T) ^ k;
    a  = e >> 4;
    b  = e & 15;
    s0 = S0[((a >> 3) & 1) * 2 + (a & 1)][(a >> 1) & 3];
    s1 = S1[((b >> 3) & 1) * 2 + (b & 1)][(b >> 1) & 3];
    return perm(s0 * 4 + s1, 4, 4, P4_T);
  endfunction

  function automatic logic [7:0] sdes_model(input logic [9:0] k, input logic [7:0] p, input logic enc);
    int unsigned t, hl, hr, k1, k2, ka, kb, ipv, l, r, tmp;
    t   = perm(32'(k), 10, 10, P10_T);
    hl  = t >> 5;
    hr  = t & 31;
    k1  = perm((rotl5(hl, 1) << 5) | rotl5(hr, 1), 10, 8, P8_T);
    k2  = perm((rotl5(hl, 3) << 5) | rotl5(hr, 3), 10, 8, P8_T);
    ka  = enc ? k1 : k2;
    kb  = enc ? k2 : k1;
    ipv = perm(32'(p), 8, 8, IP_T);
    l   = ipv >> 4;
    r   = ipv & 15;
    l   = l ^ f_model(r, ka);
    tmp = l; l = r; r = tmp;
    l   = l ^ f_model(r, kb);
    return 8'(perm((l << 4) | r, 8, 8, IPI_T));
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Monitor: every done must match the head of the scoreboard, no result may go missing
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) chk("done_unexpected", {7'b0, done}, 8'h00);
      else chk("result", ciphertext, sb.pop_front());
    end else if (sb.size() != 0) begin
      chk("done_missing", {7'b0, done}, 8'h01);
      sb.delete();
    end
  end

  task automatic issue(input logic [9:0] k, input logic [7:0] p, input logic e, input logic [7:0] exp);
    @(negedge clk);
    key = k; plaintext = p; encrypt = e; start = 1'b1;
    @(posedge clk);
    sb.push_back(exp);
    last_exp = exp;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      chk("hold_ct", ciphertext, last_exp);
      chk("hold_done", {7'b0, done}, 8'h00);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] rk;
    logic [7:0] rx, rc;
    rst_n = 1'b0; start = 1'b0; encrypt = 1'b1; key = '0; plaintext = '0;
    last_exp = 8'h00;
    #3;
    chk("reset_ct", ciphertext, 8'h00);
    chk("reset_done", {7'b0, done}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    issue(10'b1010000010, 8'b11010110, 1'b1, 8'b00111100);
    chk("k1", dut.k1, 8'b10100100);
    chk("k2", dut.k2, 8'b01000011);
    idle(3);
    issue(10'b1010000010, 8'b11010110, 1'b0, 8'b00110111);
    idle(1);
    issue(10'b1010000010, 8'b00111100, 1'b0, 8'b11010110);
    idle(1);

    issue(10'b1010000010, 8'b11010110, 1'b1, 8'b00111100);
    issue(10'b1010000010, 8'b11010110, 1'b0, 8'b00110111);
    idle(4);

    issue(10'b1010000010, 8'b11010110, 1'b1, 8'b00111100);
    #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("async_rst_ct", ciphertext, 8'h00);
    chk("async_rst_done", {7'b0, done}, 8'h00);
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_start_ct", ciphertext, 8'h00);
      chk("rst_start_done", {7'b0, done}, 8'h00);
    end
    start = 1'b0;
    rst_n = 1'b1;
    last_exp = 8'h00;
    idle(2);

    for (int i = 0; i < 1000; i++) begin
      rk = 10'($urandom);
      rx = 8'($urandom);
      rc = sdes_model(rk, rx, 1'b1);
      issue(rk, rx, 1'b1, rc);
      issue(rk, rc, 1'b0, rx);
    end
    idle(2);
    chk("scoreboard_empty", 8'(sb.size()), 8'h00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
